// File: rtl/inst_issue_unit.sv
// Instruction issue unit: replays a small program buffer to a valid/ready consumer,
// with a configurable repeat count and idle gap after every accepted instruction.
module inst_issue_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_wen,
  input  logic [AW-1:0] prog_waddr,
  input  logic [7:0]    prog_wdata,
  input  logic [AW:0]   prog_len,
  input  logic [3:0]    rep,
  input  logic [1:0]    gap,
  input  logic          start,
  input  logic          abort,
  output logic [7:0]    inst,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic          busy,
  output logic          done,
  output logic [7:0]    issued_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [AW:0]   LEN_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]    buf_mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [3:0]    pass_q, pass_d;
  logic [AW:0]   len_q, len_d;
  logic [1:0]    gap_q, gap_d;
  logic [1:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]    inst_q, inst_d;
  logic          inst_valid_q, inst_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    issued_q, issued_d;

  logic          wr_en;
  logic          xfer;
  logic          last_in_pass;
  logic [AW-1:0] next_ptr;

  assign xfer         = inst_valid_q && inst_ready;
  assign last_in_pass = ({1'b0, ptr_q} == (len_q - LEN_ONE));
  assign next_ptr     = last_in_pass ? '0 : (ptr_q + PTR_ONE);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pass_d       = pass_q;
    len_d        = len_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    done_d       = 1'b0;
    issued_d     = issued_q;
    wr_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        wr_en = prog_wen;
        if (start) begin
          issued_d = '0;
          if (prog_len != '0) begin
            state_d      = S_ISSUE;
            ptr_d        = '0;
            pass_d       = rep;
            len_d        = prog_len;
            gap_d        = gap;
            inst_d       = buf_mem[0];
            inst_valid_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        // A transfer coinciding with abort still counts.
        if (xfer) issued_d = sat_inc(issued_q);
        if (abort || (xfer && last_in_pass && (pass_q == '0))) begin
          state_d      = S_IDLE;
          inst_d       = 8'h00;
          inst_valid_d = 1'b0;
          done_d       = 1'b1;
          ptr_d        = '0;
          pass_d       = '0;
        end else if (xfer) begin
          ptr_d = next_ptr;
          if (last_in_pass) pass_d = pass_q - 4'd1;
          if (gap_q == '0) begin
            inst_d = buf_mem[next_ptr];
          end else begin
            state_d      = S_GAP;
            gap_cnt_d    = gap_q;
            inst_d       = 8'h00;
            inst_valid_d = 1'b0;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d      = S_IDLE;
          inst_d       = 8'h00;
          inst_valid_d = 1'b0;
          done_d       = 1'b1;
          ptr_d        = '0;
          pass_d       = '0;
        end else if (gap_cnt_q == 2'd1) begin
          state_d      = S_ISSUE;
          inst_d       = buf_mem[ptr_q];
          inst_valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 2'd1;
        end
      end

      default: begin
        state_d      = S_IDLE;
        inst_d       = 8'h00;
        inst_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      pass_q       <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      inst_q       <= 8'h00;
      inst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      issued_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pass_q       <= pass_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      issued_q     <= issued_d;
    end
  end

  // Program storage survives reset so a program can be replayed after recovery.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[prog_waddr] <= prog_wdata;
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign issued_cnt = issued_q;

endmodule

// File: doc/inst_issue_unit.md
INST_ISSUE_UNIT -- requirements
Module: inst_issue_unit

Interface
REQ-001 Parameter: DEPTH, 16, program buffer entries, power of two, 2..256.
REQ-002 Parameter: AW, 4, program address width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 prog_wen  input  1  program buffer write strobe.
REQ-006 prog_waddr  input  AW  program buffer write address.
REQ-007 prog_wdata  input  8  instruction word to write ({op[1:0], rs1/imm, rs2/imm, rd[1:0]}).
REQ-008 prog_len  input  AW+1  instructions per pass, 0..DEPTH; sampled at start.
REQ-009 rep  input  4  extra passes, so passes = rep+1; sampled at start.
REQ-010 gap  input  2  idle cycles inserted after each accepted instruction; sampled at start.
REQ-011 start  input  1  begin issuing; single-cycle pulse.
REQ-012 abort  input  1  terminate issuing.
REQ-013 inst  output  8  instruction presented to the consumer.
REQ-014 inst_valid  output  1  inst is valid.
REQ-015 inst_ready  input  1  consumer accepts inst.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a run completes or is aborted.
REQ-018 issued_cnt  output  8  instructions accepted in the current/last run; saturates at 255.

Function
REQ-019 States SHALL be IDLE, ISSUE, GAP; all outputs registered.
REQ-020 Transfer SHALL occur on an edge where inst_valid && inst_ready.
REQ-021 Once inst_valid rises, inst and inst_valid SHALL hold until the transfer edge; inst_valid never drops without a transfer, except on abort or reset.
REQ-022 inst SHALL be 8'h00 (NOP) whenever inst_valid is low.
REQ-023 Program buffer write: prog_wen in IDLE SHALL write prog_wdata to prog_waddr at the edge; writes SHALL be ignored while busy.
REQ-024 IDLE, start=1, prog_len>0: next edge -> ISSUE, inst_valid=1, inst=buf[0], issued_cnt=0, pointer=0, pass counter=rep; prog_len, rep and gap latched.
REQ-025 IDLE, start=1, prog_len=0: SHALL remain IDLE, pulse done the next cycle, clear issued_cnt, and issue nothing.
REQ-026 start SHALL be ignored while busy.
REQ-027 ISSUE, transfer, gap=0: next instruction SHALL be presented the following cycle, giving one instruction per cycle at full throughput.
REQ-028 ISSUE, transfer, gap>0: SHALL enter GAP with inst_valid=0 for exactly gap cycles, then return to ISSUE with the next instruction.
REQ-029 Pointer advance: pointer increments on transfer; at prog_len-1 it wraps to 0 and the pass counter decrements.
REQ-030 Transfer of the last instruction of the last pass: next edge -> IDLE, inst_valid=0, done=1 for one cycle; no GAP is inserted after it.
REQ-031 issued_cnt SHALL increment on every transfer, saturating at 255 (DEPTH=16, rep=15 gives 256 transfers and reports 255).
REQ-032 abort while busy: next edge -> IDLE, inst_valid=0, done=1 for one cycle.
REQ-033 abort in the same cycle as a transfer: the transfer SHALL count in issued_cnt.
REQ-034 abort has priority over all other transitions; abort in IDLE has no effect.
REQ-035 inst_ready while inst_valid=0 SHALL have no effect.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, inst_valid=0, inst=8'h00, busy=0, done=0, issued_cnt=0, pointer=0, and pass counter=0, including mid-run.
REQ-037 Program buffer contents SHALL NOT be cleared by reset.
REQ-038 After rst deasserts, the first start SHALL behave per REQ-024.

Verification
REQ-039 Load buf[0..2]=8'h93,8'h56,8'hE7; prog_len=3, rep=0, gap=0; start; inst_ready=1 -> inst 93,56,E7 in consecutive cycles starting 1 cycle after start; done pulses in the cycle after E7's transfer; issued_cnt=3.
REQ-040 Same program, inst_ready=0 for 4 cycles after valid rises -> inst holds 8'h93 with inst_valid=1 for all 4 cycles; sequence resumes unchanged.
REQ-041 prog_len=2, rep=2, gap=2, inst_ready=1 -> 6 transfers in order 0,1,0,1,0,1; exactly 2 invalid cycles between transfers and none after the last; issued_cnt=6.
REQ-042 Abort coincident with the 2nd transfer of a 4-instruction program -> issued_cnt=2, inst_valid=0 on the next cycle, done pulse, busy=0; a prog_wen and a start issued mid-run are both ignored.
REQ-043 Assert rst asynchronously mid-ISSUE -> outputs reach reset values before the next clock edge; after release, start re-issues from buf[0] with the buffer contents intact.
REQ-044 prog_len=0 start -> done pulse next cycle, inst_valid never rises; DEPTH=16, rep=15 full run -> issued_cnt=255.
